debug_dump_tx: RTL and testbench

Sequences the UART transmitter to ship the latched MIPS state dump (registers, memory window, PC) to the host after the debugger halts the pipe. On a start pulse it snapshots the wide dump vector, then sends a header byte, every dump byte LSB-byte-first, and an XOR checksum byte. Each byte goes through the tx_start/tx_done handshake. Sits between the debugger FSM (start, done_send) and the UART TX core.

---
 rtl/debug_dump_tx_pkg.sv | 25 ++
 rtl/debug_dump_tx_byte_select.sv | 21 ++
 rtl/debug_dump_tx.sv | 137 +++++++++++++
 tb/tb_debug_dump_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_dump_tx_pkg.sv
// Shared definitions for the debug dump transmitter.
//   HEADER_DEFAULT : first byte of every dump frame
//   dump_state_e   : sequencer state encoding (IDLE, ISSUE, WAIT, DONE)
//   clog2          : ceiling log2, used to size the frame byte index
package debug_dump_tx_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debug_dump_tx_byte_select.sv
// Combinational byte mux over the latched dump vector.
//   data     : N_BYTES*8 bit vector, byte k = data[8k+7:8k]
//   sel      : byte number to select (0 .. N_BYTES-1)
//   byte_out : selected byte, 0 when sel is out of range
module debug_dump_tx_byte_select #(
  parameter int N_BYTES = 320,
  parameter int IDX_W   = 9
) (
  input  logic [N_BYTES*8-1:0] data,
  input  logic [IDX_W-1:0]     sel,
  output logic [7:0]           byte_out
);

  always_comb begin
    byte_out = 8'h00;
    for (int k = 0; k < N_BYTES; k++) begin
      if (sel == IDX_W'(k)) byte_out = data[8*k +: 8];
    end
  end

endmodule

// File: rtl/debug_dump_tx.sv
// Ships the latched MIPS state dump to the host through the UART TX core.
// Frame: HEADER, dump bytes 0..N_BYTES-1 (LSB byte first), XOR checksum of
// the dump bytes (header excluded).
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_start           : one-cycle request, honoured only in IDLE
//   i_data_from_mips  : dump vector, snapshotted on the accepted start edge
//   is_tx_done        : UART pulse, current byte fully shifted out
//   o_tx_data         : byte being transmitted
//   os_tx_start       : one-cycle pulse, UART loads o_tx_data
//   o_done_send       : one-cycle pulse, frame complete
//   o_busy            : high while a frame is in flight (through DONE)
//   dbg_state         : current sequencer state
//
// Handshake: os_tx_start is a one-cycle "valid" pulse; o_tx_data is valid
// from that cycle and held until the UART answers with a one-cycle
// is_tx_done ("ready/complete"). is_tx_done is only honoured in WAIT, so a
// pulse in the issue cycle, in IDLE or in DONE is dropped.
module debug_dump_tx
  import debug_dump_tx_pkg::*;
#(
  parameter int         N_BYTES = 320,
  parameter logic [7:0] HEADER  = HEADER_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [N_BYTES*8-1:0] i_data_from_mips,
  input  logic                 is_tx_done,
  output logic [7:0]           o_tx_data,
  output logic                 os_tx_start,
  output logic                 o_done_send,
  output logic                 o_busy,
  output dump_state_e          dbg_state
);

  localparam int              IDX_W    = clog2(N_BYTES + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES + 1);
  localparam logic [IDX_W-1:0] CHK_PREV = IDX_W'(N_BYTES);

  dump_state_e          state, state_nxt;
  logic [IDX_W-1:0]     byte_idx;
  logic [7:0]           chk;
  logic [N_BYTES*8-1:0] snapshot;
  logic [7:0]           tx_data_q;
  logic [7:0]           sel_byte;

  logic                 load_first;
  logic                 load_next;

  // The byte register is loaded on the edge that enters ISSUE, so the byte
  // is already valid in the os_tx_start cycle. The next frame index is
  // byte_idx+1, whose snapshot byte is (byte_idx+1)-1 = byte_idx.
  debug_dump_tx_byte_select #(
    .N_BYTES (N_BYTES),
    .IDX_W   (IDX_W)
  ) u_byte_select (
    .data     (snapshot),
    .sel      (byte_idx),
    .byte_out (sel_byte)
  );

  always_comb begin
    state_nxt   = state;
    load_first  = 1'b0;
    load_next   = 1'b0;
    os_tx_start = 1'b0;
    o_done_send = 1'b0;
    o_busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          load_first = 1'b1;
          state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        os_tx_start = 1'b1;
        o_busy      = 1'b1;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        o_busy = 1'b1;
        if (is_tx_done) begin
          if (byte_idx == LAST_IDX) begin
            state_nxt = ST_DONE;
          end else begin
            load_next = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        o_done_send = 1'b1;
        o_busy      = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx  <= '0;
      chk       <= 8'h00;
      snapshot  <= '0;
      tx_data_q <= 8'h00;
    end else if (load_first) begin
      snapshot  <= i_data_from_mips;
      byte_idx  <= '0;
      chk       <= 8'h00;
      tx_data_q <= HEADER;
    end else if (load_next) begin
      byte_idx <= byte_idx + 1'b1;
      if (byte_idx == CHK_PREV) begin
        // every data byte has been folded into chk by now
        tx_data_q <= chk;
      end else begin
        tx_data_q <= sel_byte;
        chk       <= chk ^ sel_byte;
      end
    end
  end

  assign o_tx_data = tx_data_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_debug_dump_tx.sv
module tb_debug_dump_tx;
  import debug_dump_tx_pkg::*;

  localparam int NA = 4;
  localparam int NB = 320;
  localparam int WB = NB * 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  // ---------------- shared drive / observe ----------------
  logic          sel_b;
  logic          start_drv, done_drv;
  logic [WB-1:0] data_drv;

  logic            start_a, start_b, done_a, done_b;
  logic [NA*8-1:0] data_a;
  logic [WB-1:0]   data_b;

  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_start_a, tx_start_b, done_send_a, done_send_b, busy_a, busy_b;
  dump_state_e st_a, st_b;

  assign start_a = start_drv & ~sel_b;
  assign start_b = start_drv & sel_b;
  assign done_a  = done_drv & ~sel_b;
  assign done_b  = done_drv & sel_b;
  assign data_a  = data_drv[NA*8-1:0];
  assign data_b  = data_drv;

  logic [7:0]  obs_data;
  logic        obs_start, obs_done_send, obs_busy;
  dump_state_e obs_state;

  assign obs_data      = sel_b ? tx_data_b   : tx_data_a;
  assign obs_start     = sel_b ? tx_start_b  : tx_start_a;
  assign obs_done_send = sel_b ? done_send_b : done_send_a;
  assign obs_busy      = sel_b ? busy_b      : busy_a;
  assign obs_state     = sel_b ? st_b        : st_a;

  debug_dump_tx #(.N_BYTES(NA)) dut_a (
    .clk              (clk),
    .rst              (rst_a),
    .i_start          (start_a),
    .i_data_from_mips (data_a),
    .is_tx_done       (done_a),
    .o_tx_data        (tx_data_a),
    .os_tx_start      (tx_start_a),
    .o_done_send      (done_send_a),
    .o_busy           (busy_a),
    .dbg_state        (st_a)
  );

  debug_dump_tx dut_b (
    .clk              (clk),
    .rst              (rst_b),
    .i_start          (start_b),
    .i_data_from_mips (data_b),
    .is_tx_done       (done_b),
    .o_tx_data        (tx_data_b),
    .os_tx_start      (tx_start_b),
    .o_done_send      (done_send_b),
    .o_busy           (busy_b),
    .dbg_state        (st_b)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: header, dump bytes low first, XOR of the dump bytes.
  task automatic build_expected(input int n, input logic [WB-1:0] data);
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(data[8*k +: 8]);
      x = x ^ data[8*k +: 8];
    end
    exp_q.push_back(x);
  endtask

  // ---------------- driver ----------------
  // mode 0: normal, 3: re-start + data change, 4: done coincident with
  // the second issue, 5: reset in WAIT of the third byte.
  task automatic run_frame(input int n, input logic [WB-1:0] data, input int mode, input int dly);
    logic [7:0] held;
    int idx, cyc, budget, due, issue_cyc, last_done_cyc, bad;
    bit pending, finished, aborted;
    build_expected(n, data);
    held = 8'h00;
    data_drv  = data;
    start_drv = 1'b1;
    step();
    start_drv = 1'b0;
    check_eq("start_latency", obs_start, 1);
    check_eq("busy_on", obs_busy, 1);
    if (mode == 3) data_drv = '1;
    idx = 0; cyc = 0; due = 0; issue_cyc = 0; last_done_cyc = -10;
    pending = 0; finished = 0; aborted = 0;
    budget = (n + 2) * (dly + 4) + 50;
    while (!finished && cyc < budget) begin
      done_drv  = 1'b0;
      start_drv = 1'b0;
      if (obs_start) begin
        check_eq("issue_while_wait", pending, 0);
        if (idx >= exp_q.size()) check_eq("extra_byte", idx, exp_q.size());
        else check_eq($sformatf("byte%0d", idx), obs_data, exp_q[idx]);
        if (idx > 0) check_eq("issue_latency", cyc, last_done_cyc + 1);
        held = obs_data; idx++; pending = 1; issue_cyc = cyc; due = cyc + dly;
        if (mode == 4 && idx == 2) done_drv = 1'b1;
      end else if (obs_done_send) begin
        check_eq("done_byte_count", idx, exp_q.size());
        check_eq("done_latency", cyc, last_done_cyc + 1);
        check_eq("busy_in_done", obs_busy, 1);
        finished = 1;
      end else begin
        if (mode == 4 && idx == 2 && pending && cyc < due) begin
          check_eq("coincident_state", obs_state, ST_WAIT);
          check_eq("coincident_hold", obs_data, held);
        end
        if (mode == 3 && idx == 2 && cyc == issue_cyc + 1) start_drv = 1'b1;
        if (mode == 5 && idx == 3 && cyc == issue_cyc + 1) begin
          rst_a = 1'b0;
          #1;
          check_eq("abort_data", obs_data, 0);
          check_eq("abort_start", obs_start, 0);
          check_eq("abort_done", obs_done_send, 0);
          check_eq("abort_busy", obs_busy, 0);
          aborted = 1; finished = 1; pending = 0;
        end
        if (pending && cyc == due) begin
          check_eq("hold_data", obs_data, held);
          done_drv = 1'b1; pending = 0; last_done_cyc = cyc;
        end
      end
      if (!finished || aborted) begin
        step();
        cyc++;
      end
    end
    done_drv = 1'b0;
    start_drv = 1'b0;
    check_eq("frame_finished", finished, 1);
    if (aborted) begin
      rst_a = 1'b1;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
        step();
        if (obs_start || obs_done_send) bad++;
      end
      check_eq("quiet_after_reset", bad, 0);
    end else begin
      step();
      check_eq("busy_off", obs_busy, 0);
      check_eq("done_single", obs_done_send, 0);
      if (mode == 3) begin
        bad = 0;
        for (int c = 0; c < 20; c++) begin
          step();
          if (obs_start || obs_done_send) bad++;
        end
        check_eq("no_second_frame", bad, 0);
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    logic [WB-1:0] rnd;
    rst_a = 1'b0; rst_b = 1'b0;
    sel_b = 1'b0; start_drv = 1'b0; done_drv = 1'b0; data_drv = '0;
    step(); step();
    for (int s = 0; s < 2; s++) begin
      sel_b = s[0];
      #1;
      check_eq("rst_data", obs_data, 0);
      check_eq("rst_start", obs_start, 0);
      check_eq("rst_done", obs_done_send, 0);
      check_eq("rst_busy", obs_busy, 0);
      check_eq("rst_state", obs_state, ST_IDLE);
    end
    sel_b = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    step(); step();

    run_frame(NA, WB'(32'h04030201), 0, 3);
    run_frame(NA, WB'(32'h04030201), 3, 2);
    run_frame(NA, WB'(32'h0A0B0C0D), 4, 3);
    run_frame(NA, WB'(32'h04030201), 5, 3);
    step();
    run_frame(NA, WB'(32'h11223344), 0, 1);
    run_frame(NA, WB'(32'h80402010), 0, 2);
    for (int r = 0; r < 6; r++) begin
      run_frame(NA, WB'($urandom), 0, $urandom_range(1, 5));
    end

    sel_b = 1'b1;
    step();
    run_frame(NB, '0, 0, 1);
    rnd = '0;
    for (int w = 0; w < NB / 4; w++) rnd[32*w +: 32] = $urandom;
    run_frame(NB, rnd, 0, $urandom_range(1, 3));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
